// File: rtl/redmule_x_buffer_pp.sv
// Ping-pong X-operand buffer: two tile banks, one loading while the other streams depth slices.
// Latency: first slice valid the cycle after the last row beat of a tile; one slice per out handshake.
// Backpressure: load_ready_o drops while the write bank is FULL; slices hold until out_ready_i.
//
// Ports:
//   clk_i, rst_ni              clock, asynchronous active-low reset
//   clear_i                    synchronous soft clear (banks emptied, pointers zeroed, data kept)
//   load_valid_i/load_ready_o  row beat handshake, x_buffer_i carries one tile row (DW bits)
//   cols_lftovr_i              valid elements per row (0 = TOT_DEPTH), sampled every beat
//   rows_lftovr_i, slots_i     rows per tile (0 = Width), slices to stream (0 = D), latched at first beat
//   out_valid_o/out_ready_i    slice handshake, x_buffer_o = [Width][Height][BITW] current slice
//   replay_i                   re-stream request on the final slice
//   empty_o, full_o            both banks EMPTY / both banks FULL
//
// Optional feature: define REDMULE_XBUF_REPLAY_EN to honour replay_i.
// FpFormat uses the fpnew_pkg::fp_format_e encoding (FP32=0, FP64=1, FP16=2, FP8=3, FP16ALT=4)
// so the block stays self-contained; Height/Width defaults match a 4x4 array.

module redmule_x_buffer_pp #(
   parameter int unsigned DW        = 256,
   parameter int unsigned FpFormat  = 2,
   parameter int unsigned Height    = 4,
   parameter int unsigned Width     = 4,
   localparam int unsigned BITW     = (FpFormat == 0) ? 32 :
                                      (FpFormat == 1) ? 64 :
                                      (FpFormat == 3) ? 8  : 16,
   localparam int unsigned D         = DW / (Height * BITW),
   localparam int unsigned TOT_DEPTH = Height * D,
   localparam int unsigned CW        = $clog2(TOT_DEPTH) + 1,
   localparam int unsigned RW        = $clog2(Width) + 1,
   localparam int unsigned SW        = $clog2(D) + 1
) (
   input  logic                                      clk_i,
   input  logic                                      rst_ni,
   input  logic                                      clear_i,
   input  logic                                      load_valid_i,
   output logic                                      load_ready_o,
   input  logic [DW-1:0]                             x_buffer_i,
   input  logic [CW-1:0]                             cols_lftovr_i,
   input  logic [RW-1:0]                             rows_lftovr_i,
   input  logic [SW-1:0]                             slots_i,
   output logic                                      out_valid_o,
   input  logic                                      out_ready_i,
   output logic [Width-1:0][Height-1:0][BITW-1:0]    x_buffer_o,
   input  logic                                      replay_i,
   output logic                                      empty_o,
   output logic                                      full_o
);

   localparam int unsigned WIW = (Width > 1) ? $clog2(Width) : 1;
   localparam int unsigned DIW = (D > 1) ? $clog2(D) : 1;

   typedef logic [Width-1:0][Height-1:0][BITW-1:0] slice_t;
   typedef slice_t [D-1:0] bank_t;
   typedef enum logic [1:0] {BANK_EMPTY, BANK_FILLING, BANK_FULL} bank_state_e;

   bank_t [1:0]    data_q, data_d;
   bank_state_e    state_q [2];
   bank_state_e    state_d [2];
   logic [RW-1:0]  rows_q [2];
   logic [RW-1:0]  rows_d [2];
   logic [SW-1:0]  slots_q [2];
   logic [SW-1:0]  slots_d [2];
   logic           wbank_q, wbank_d;
   logic           rbank_q, rbank_d;
   logic [WIW-1:0] w_idx_q, w_idx_d;
   logic [DIW-1:0] d_idx_q, d_idx_d;

   logic [RW-1:0]  rows_in, rows_eff;
   logic [SW-1:0]  slots_in;
   logic [CW-1:0]  depth;
   logic           load_fire, out_fire, last_row, last_slot;

   // Zero-encoded "full" counts decoded to their real values.
   assign rows_in  = (rows_lftovr_i == '0) ? RW'(Width) : rows_lftovr_i;
   assign slots_in = (slots_i == '0) ? SW'(D) : slots_i;
   assign depth    = (cols_lftovr_i == '0) ? CW'(TOT_DEPTH) : cols_lftovr_i;

   assign load_ready_o = (state_q[wbank_q] != BANK_FULL);
   assign out_valid_o  = (state_q[rbank_q] == BANK_FULL);
   assign load_fire    = load_valid_i & load_ready_o;
   assign out_fire     = out_valid_o & out_ready_i;

   // The first beat of a tile must use the incoming row count, it is not latched yet.
   assign rows_eff  = (state_q[wbank_q] == BANK_EMPTY) ? rows_in : rows_q[wbank_q];
   assign last_row  = ((RW'(w_idx_q) + RW'(1)) == rows_eff);
   assign last_slot = ((SW'(d_idx_q) + SW'(1)) == slots_q[rbank_q]);

   assign empty_o = (state_q[0] == BANK_EMPTY) & (state_q[1] == BANK_EMPTY);
   assign full_o  = (state_q[0] == BANK_FULL)  & (state_q[1] == BANK_FULL);

`ifndef REDMULE_XBUF_REPLAY_EN
   logic replay_unused;
   assign replay_unused = replay_i;
`endif

   always_comb begin
      data_d  = data_q;
      state_d = state_q;
      rows_d  = rows_q;
      slots_d = slots_q;
      wbank_d = wbank_q;
      rbank_d = rbank_q;
      w_idx_d = w_idx_q;
      d_idx_d = d_idx_q;
      if (clear_i) begin
         state_d[0] = BANK_EMPTY;
         state_d[1] = BANK_EMPTY;
         wbank_d    = 1'b0;
         rbank_d    = 1'b0;
         w_idx_d    = '0;
         d_idx_d    = '0;
      end else begin
         // A load and a release never target the same bank: the write bank
         // is not FULL while loading, the read bank is FULL while streaming.
         if (load_fire) begin
            for (int d = 0; d < int'(D); d++) begin
               for (int h = 0; h < int'(Height); h++) begin
                  if ((d * int'(Height) + h) < int'(depth)) begin
                     data_d[wbank_q][d][w_idx_q][h] =
                        x_buffer_i[(d * int'(Height) + h) * int'(BITW) +: BITW];
                  end else begin
                     data_d[wbank_q][d][w_idx_q][h] = '0;
                  end
               end
            end
            if (state_q[wbank_q] == BANK_EMPTY) begin
               rows_d[wbank_q]  = rows_in;
               slots_d[wbank_q] = slots_in;
               state_d[wbank_q] = BANK_FILLING;
            end
            if (last_row) begin
               state_d[wbank_q] = BANK_FULL;
               w_idx_d          = '0;
               wbank_d          = ~wbank_q;
            end else begin
               w_idx_d = w_idx_q + WIW'(1);
            end
         end
         if (out_fire) begin
            if (last_slot) begin
               d_idx_d = '0;
`ifdef REDMULE_XBUF_REPLAY_EN
               if (!replay_i) begin
                  state_d[rbank_q] = BANK_EMPTY;
                  rbank_d          = ~rbank_q;
               end
`else
               state_d[rbank_q] = BANK_EMPTY;
               rbank_d          = ~rbank_q;
`endif
            end else begin
               d_idx_d = d_idx_q + DIW'(1);
            end
         end
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         data_q     <= '0;
         state_q[0] <= BANK_EMPTY;
         state_q[1] <= BANK_EMPTY;
         rows_q[0]  <= '0;
         rows_q[1]  <= '0;
         slots_q[0] <= '0;
         slots_q[1] <= '0;
         wbank_q    <= 1'b0;
         rbank_q    <= 1'b0;
         w_idx_q    <= '0;
         d_idx_q    <= '0;
      end else begin
         data_q  <= data_d;
         state_q <= state_d;
         rows_q  <= rows_d;
         slots_q <= slots_d;
         wbank_q <= wbank_d;
         rbank_q <= rbank_d;
         w_idx_q <= w_idx_d;
         d_idx_q <= d_idx_d;
      end
   end

   // Rows beyond the latched row count may hold a previous tile's data, so mask them.
   always_comb begin
      x_buffer_o = '0;
      if (out_valid_o) begin
         for (int w = 0; w < int'(Width); w++) begin
            if (w < int'(rows_q[rbank_q])) begin
               x_buffer_o[w] = data_q[rbank_q][d_idx_q][w];
            end
         end
      end
   end

endmodule

// File: tb/tb_redmule_x_buffer_pp.sv
module tb_redmule_x_buffer_pp;

   typedef logic [3:0][3:0][15:0]       slice_t;
   typedef logic [3:0][3:0][3:0][15:0]  tile_t;   // [slice][row][h][bits]

   logic         clk = 1'b0;
   logic         rst_n;
   logic         clear;
   logic         load_valid;
   logic         load_ready;
   logic [255:0] x_in;
   logic [4:0]   cols;
   logic [2:0]   rows;
   logic [2:0]   slots;
   logic         out_valid;
   logic         out_ready;
   slice_t       x_out;
   logic         replay;
   logic         empty;
   logic         full;

   int total = 0;
   int bad   = 0;

   // Reference model: queue of completed tiles plus one partial tile.
   tile_t tq[$];
   int    ts[$];
   int    rd_pos;
   bit    p_active;
   int    p_rows, p_slots, p_cnt;
   tile_t p_tile;

   always #5 clk = ~clk;

   redmule_x_buffer_pp #(
      .DW(256), .FpFormat(2), .Height(4), .Width(4)
   ) dut (
      .clk_i(clk), .rst_ni(rst_n), .clear_i(clear),
      .load_valid_i(load_valid), .load_ready_o(load_ready), .x_buffer_i(x_in),
      .cols_lftovr_i(cols), .rows_lftovr_i(rows), .slots_i(slots),
      .out_valid_o(out_valid), .out_ready_i(out_ready), .x_buffer_o(x_out),
      .replay_i(replay), .empty_o(empty), .full_o(full)
   );

   function automatic logic [255:0] rnd256();
      logic [255:0] r;
      for (int i = 0; i < 8; i++) r[i*32 +: 32] = $urandom;
      return r;
   endfunction

   function automatic int dec(input int v, input int full_val);
      return (v == 0) ? full_val : v;
   endfunction

   task automatic model_reset();
      tq.delete();
      ts.delete();
      rd_pos   = 0;
      p_active = 0;
      p_cnt    = 0;
      p_tile   = '0;
   endtask

   task automatic model_load(input logic [255:0] beat, input int c, input int r, input int s);
      int depth;
      if (!p_active) begin
         p_rows   = dec(r, 4);
         p_slots  = dec(s, 4);
         p_tile   = '0;
         p_cnt    = 0;
         p_active = 1;
      end
      depth = dec(c, 16);
      for (int sl = 0; sl < 4; sl++)
         for (int h = 0; h < 4; h++)
            p_tile[sl][p_cnt][h] = ((4*sl + h) < depth) ? beat[(4*sl + h)*16 +: 16] : 16'h0;
      p_cnt++;
      if (p_cnt == p_rows) begin
         tq.push_back(p_tile);
         ts.push_back(p_slots);
         p_active = 0;
      end
   endtask

   task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // One clock: check outputs at the negedge, then advance the model past the posedge.
   task automatic cyc();
      bit           exp_rdy, exp_vld, lfire, ofire, c_clr, keep;
      logic [255:0] c_x;
      int           c_c, c_r, c_s;
      slice_t       exp_x;
      @(negedge clk);
      exp_rdy = (tq.size() < 2);
      exp_vld = (tq.size() > 0);
      exp_x   = exp_vld ? tq[0][rd_pos] : '0;
      chk("load_ready", load_ready, exp_rdy);
      chk("out_valid", out_valid, exp_vld);
      chk("x_buffer_o", x_out, exp_x);
      chk("empty", empty, (tq.size() == 0) && !p_active);
      chk("full", full, tq.size() == 2);
      lfire = load_valid && exp_rdy && rst_n;
      ofire = exp_vld && out_ready && rst_n;
      c_clr = clear;
      c_x = x_in; c_c = cols; c_r = rows; c_s = slots;
      keep = 0;
`ifdef REDMULE_XBUF_REPLAY_EN
      keep = replay;
`endif
      @(posedge clk);
      #1;
      if (!rst_n || c_clr) begin
         model_reset();
      end else begin
         if (ofire) begin
            rd_pos++;
            if (rd_pos == ts[0]) begin
               rd_pos = 0;
               if (!keep) begin
                  void'(tq.pop_front());
                  void'(ts.pop_front());
               end
            end
         end
         if (lfire) model_load(c_x, c_c, c_r, c_s);
      end
   endtask

   // Present one beat and hold it until the model says it is taken (bounded).
   task automatic send(input int c, input int r, input int s);
      bit acc;
      int n;
      n = 0;
      load_valid = 1'b1;
      x_in  = rnd256();
      cols  = 5'(c);
      rows  = 3'(r);
      slots = 3'(s);
      do begin
         acc = (tq.size() < 2);
         cyc();
         n++;
      end while (!acc && n < 64);
   endtask

   task automatic idle(input int n);
      load_valid = 1'b0;
      repeat (n) cyc();
   endtask

   initial begin
      rst_n = 1'b0; clear = 1'b0; load_valid = 1'b0; x_in = '0;
      cols = '0; rows = '0; slots = '0; out_ready = 1'b0; replay = 1'b0;
      model_reset();
      // Reset state
      cyc();
      cyc();
      rst_n = 1'b1;
      cyc();

      // Four full beats, streaming immediately
      out_ready = 1'b1;
      repeat (4) send(0, 0, 0);
      idle(8);

      // Partial column count: 6 valid elements per row
      repeat (4) send(6, 0, 0);
      idle(6);

      // Two rows, two slots; later beat's rows/slots must be ignored
      send(0, 2, 2);
      send(0, 3, 1);
      idle(4);

      // Three tiles back to back with the sink stalled
      out_ready = 1'b0;
      repeat (8) send(0, 0, 0);
      load_valid = 1'b1;
      x_in = rnd256();
      repeat (3) cyc();
      out_ready = 1'b1;
      repeat (4) send(0, 0, 0);
      idle(20);

      // Clear during beat 2 of a tile
      out_ready = 1'b0;
      send(0, 0, 0);
      clear = 1'b1;
      send(0, 0, 0);
      clear = 1'b0;
      repeat (4) send(3, 0, 0);
      out_ready = 1'b1;
      idle(8);

      // Replay request on the final slice
      repeat (4) send(0, 0, 0);
      load_valid = 1'b0;
      replay = 1'b1;
      repeat (4) cyc();
      replay = 1'b0;
      idle(8);

      // Reset asserted mid-tile
      out_ready = 1'b0;
      send(0, 0, 0);
      send(0, 0, 0);
      load_valid = 1'b0;
      rst_n = 1'b0;
      model_reset();
      cyc();
      rst_n = 1'b1;
      repeat (4) send(0, 0, 0);
      out_ready = 1'b1;
      idle(6);

      // Randomized traffic
      for (int i = 0; i < 600; i++) begin
         load_valid = ($urandom_range(0, 2) != 0);
         x_in       = rnd256();
         cols       = 5'($urandom_range(0, 16));
         rows       = 3'($urandom_range(0, 4));
         slots      = 3'($urandom_range(0, 4));
         out_ready  = ($urandom_range(0, 1) == 1);
         clear      = ($urandom_range(0, 39) == 0);
         replay     = ($urandom_range(0, 3) == 0);
         cyc();
      end
      clear = 1'b0;
      replay = 1'b0;
      idle(4);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
